// File: rtl/tcam_prio.sv
// Ternary CAM with per-entry valid/mask, flush, and a 2-stage search
// reporting lowest-index hit, multi-hit flag and hit count.
module tcam_prio #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 6,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic                  write_valid,
  input  logic                  flush,
  output logic                  done,
  output logic                  match,
  output logic                  multi_match,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic [ADDR_WIDTH:0]   match_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NSL   = DATA_WIDTH / SLICE_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]      r_data [DEPTH];
  logic [DATA_WIDTH-1:0]      r_mask [DEPTH];
  logic [DEPTH-1:0]           r_valid;

  logic                       r_s1_vld;
  logic [DEPTH-1:0][NSL-1:0]  r_slice;
  logic [DEPTH-1:0]           r_s1_valid;

  logic [DEPTH-1:0][NSL-1:0]  w_eq;
  logic [DEPTH-1:0]           w_hit;
  logic [ADDR_WIDTH-1:0]      w_addr;
  logic [CW-1:0]              w_cnt;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [DATA_WIDTH-1:0] w_diff;
    assign w_diff = (din ^ r_data[gi]) & ~r_mask[gi];
    for (genvar gs = 0; gs < NSL; gs++) begin : g_sl
      assign w_eq[gi][gs] =
        ~|w_diff[gs*SLICE_WIDTH +: SLICE_WIDTH];
    end
    assign w_hit[gi] = r_s1_valid[gi] & (&r_slice[gi]);
  end

  // Walk from the top so the lowest index wins.
  always_comb begin
    w_addr = '0;
    w_cnt  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_addr = ADDR_WIDTH'(i);
      end
      w_cnt = w_cnt + CW'(w_hit[i]);
    end
  end

  // Write applied after flush so a same-edge write keeps its entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end
      if (write_enable) begin
        r_valid[write_addr] <= write_valid;
        if (write_valid) begin
          r_data[write_addr] <= write_data;
          r_mask[write_addr] <= write_mask;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_vld   <= 1'b0;
      r_slice    <= '0;
      r_s1_valid <= '0;
    end else begin
      r_s1_vld <= start;
      if (start) begin
        r_slice    <= w_eq;
        r_s1_valid <= r_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done        <= 1'b0;
      match       <= 1'b0;
      multi_match <= 1'b0;
      match_addr  <= '0;
      match_count <= '0;
    end else begin
      done <= r_s1_vld;
      if (r_s1_vld) begin
        match       <= |w_hit;
        multi_match <= w_cnt > CW'(1);
        match_addr  <= w_addr;
        match_count <= w_cnt;
      end
    end
  end

endmodule

// File: tb/tb_tcam_prio.sv
// Directed bench for tcam_prio: reset, masking, invalidate/flush,
// write/search ordering and reset during in-flight searches.
module tb_tcam_prio;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic         write_enable;
  logic [5:0]   write_addr;
  logic [127:0] write_data;
  logic [127:0] write_mask;
  logic         write_valid;
  logic         flush;
  logic         done;
  logic         match;
  logic         multi_match;
  logic [5:0]   match_addr;
  logic [6:0]   match_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] res;
  assign res = {done, match, multi_match, match_addr, match_count};

  tcam_prio dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .write_mask(write_mask),
    .write_valid(write_valid), .flush(flush),
    .done(done), .match(match), .multi_match(multi_match),
    .match_addr(match_addr), .match_count(match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_res(
    input logic d, input logic m, input logic mm,
    input logic [5:0] a, input logic [6:0] c);
    return {d, m, mm, a, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [127:0] d,
                    input logic [127:0] m, input logic v);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    write_mask   = m;
    write_valid  = v;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic run_search(input logic [127:0] key,
                            output logic early_done);
    start = 1'b1;
    din   = key;
    tick();
    start      = 1'b0;
    early_done = done;
    tick();
  endtask

  task automatic test_reset;
    logic ed;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (res !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want %h", res, 16'h0);
    end
    rst = 1'b1;
    run_search(128'h0, ed);
    checks++;
    if (ed !== 1'b0) begin
      failures++;
      $display("FAIL empty_early_done: got %b want 0", ed);
    end
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL empty_search: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_multi;
    logic ed;
    wr(6'd0, 128'h0, 128'h0, 1'b1);
    wr(6'd1, 128'h0, 128'h0, 1'b1);
    run_search(128'h0, ed);
    checks++;
    if (res !== exp_res(1, 1, 1, 0, 2)) begin
      failures++;
      $display("FAIL multi_hit: got %h want %h",
               res, exp_res(1, 1, 1, 0, 2));
    end
    tick();
    checks++;
    if (res !== exp_res(0, 1, 1, 0, 2)) begin
      failures++;
      $display("FAIL hold_after_done: got %h want %h",
               res, exp_res(0, 1, 1, 0, 2));
    end
    run_search(128'h1111, ed);
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL multi_miss: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_mask;
    logic ed;
    wr(6'd5, 128'hABCD, 128'hF, 1'b1);
    run_search(128'hABC3, ed);
    checks++;
    if (res !== exp_res(1, 1, 0, 5, 1)) begin
      failures++;
      $display("FAIL mask_hit: got %h want %h",
               res, exp_res(1, 1, 0, 5, 1));
    end
    run_search(128'hAB0D, ed);
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL mask_miss: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
    wr(6'd9, 128'h0, {128{1'b1}}, 1'b1);
    run_search(128'h1234, ed);
    checks++;
    if (res !== exp_res(1, 1, 0, 9, 1)) begin
      failures++;
      $display("FAIL wildcard_hit: got %h want %h",
               res, exp_res(1, 1, 0, 9, 1));
    end
    run_search(128'hABC3, ed);
    checks++;
    if (res !== exp_res(1, 1, 1, 5, 2)) begin
      failures++;
      $display("FAIL wildcard_prio: got %h want %h",
               res, exp_res(1, 1, 1, 5, 2));
    end
    wr(6'd9, 128'h0, 128'h0, 1'b0);
  endtask

  task automatic test_invalidate_flush;
    logic ed;
    wr(6'd0, 128'hDEAD, 128'h0, 1'b0);
    run_search(128'h0, ed);
    checks++;
    if (res !== exp_res(1, 1, 0, 1, 1)) begin
      failures++;
      $display("FAIL invalidate: got %h want %h",
               res, exp_res(1, 1, 0, 1, 1));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_search(128'h0, ed);
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL flush_miss: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
    wr(6'd1, 128'h0, 128'h0, 1'b1);
    flush = 1'b1;
    wr(6'd7, 128'h55, 128'h0, 1'b1);
    flush = 1'b0;
    run_search(128'h55, ed);
    checks++;
    if (res !== exp_res(1, 1, 0, 7, 1)) begin
      failures++;
      $display("FAIL flush_write_wins: got %h want %h",
               res, exp_res(1, 1, 0, 7, 1));
    end
    run_search(128'h0, ed);
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL flush_others: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back;
    write_enable = 1'b1;
    write_addr   = 6'd3;
    write_data   = 128'h77;
    write_mask   = 128'h0;
    write_valid  = 1'b1;
    start        = 1'b1;
    din          = 128'h77;
    tick();
    write_enable = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early: got %b want 0", done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL same_edge_write: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
    tick();
    checks++;
    if (res !== exp_res(1, 1, 0, 3, 1)) begin
      failures++;
      $display("FAIL next_edge_write: got %h want %h",
               res, exp_res(1, 1, 0, 3, 1));
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail: got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid;
    logic ed;
    int   extra;
    start = 1'b1;
    din   = 128'h77;
    tick();
    din = 128'h78;
    tick();
    checks++;
    if (res !== exp_res(1, 1, 0, 3, 1)) begin
      failures++;
      $display("FAIL pre_reset_done: got %h want %h",
               res, exp_res(1, 1, 0, 3, 1));
    end
    din = 128'h77;
    rst = 1'b0;
    tick();
    checks++;
    if (res !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_out: got %h want %h", res, 16'h0);
    end
    start = 1'b0;
    rst   = 1'b1;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL discarded_done: got %0d want 0", extra);
    end
    run_search(128'h77, ed);
    checks++;
    if (res !== exp_res(1, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL storage_cleared: got %h want %h",
               res, exp_res(1, 0, 0, 0, 0));
    end
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    din          = '0;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    write_mask   = '0;
    write_valid  = 1'b0;
    flush        = 1'b0;
    test_reset();
    test_multi();
    test_mask();
    test_invalidate_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
